// File: rtl/div_ctrl_pkg.sv
// Shared constants and state encoding for the divider controller.
package div_ctrl_pkg;

  localparam int REG_WIDTH = 32;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic [REG_WIDTH-1:0] ZERO_WORD = '0;

  // GUARD holds off a restart until the divider has left DivByZero/DivEnd.
  localparam logic [1:0] GUARD_LOAD = 2'd3;

  typedef enum logic [1:0] {
    DIV_CTRL_IDLE    = 2'b00,
    DIV_CTRL_BUSY    = 2'b01,
    DIV_CTRL_RELEASE = 2'b10,
    DIV_CTRL_GUARD   = 2'b11
  } div_ctrl_state_e;

endpackage

// File: rtl/gnrl_dfflr.sv
// Generic D flip-flop with load enable and synchronous active-high reset to zero.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_lden,
  input  logic [DW-1:0] i_dnxt,
  output logic [DW-1:0] o_qout
);

  logic [DW-1:0] r_q;

  // Capture on load enable; reset clears to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_lden) begin
      r_q <= i_dnxt;
    end
  end

  assign o_qout = r_q;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: starts it, stalls the pipe,
// strobes the HI/LO write on completion, and annuls it on a flush.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_req_i,
  input  logic                 div_signed_i,
  input  logic [REG_WIDTH-1:0] rs_data_i,
  input  logic [REG_WIDTH-1:0] rt_data_i,
  input  logic                 flush_i,
  input  logic [63:0]          div_result_i,
  input  logic                 div_ready_i,
  output logic                 div_start_o,
  output logic                 div_annul_o,
  output logic                 div_signed_o,
  output logic [REG_WIDTH-1:0] div_op1_o,
  output logic [REG_WIDTH-1:0] div_op2_o,
  output logic                 stallreq_o,
  output logic                 whilo_o,
  output logic [REG_WIDTH-1:0] hi_o,
  output logic [REG_WIDTH-1:0] lo_o
);

  logic [1:0]      r_state;
  logic [1:0]      r_cnt;
  div_ctrl_state_e w_state;
  div_ctrl_state_e w_state_nxt;
  logic [1:0]      w_state_nxt_bits;
  logic [1:0]      w_cnt_nxt;
  logic            w_start_nxt;
  logic            w_annul_nxt;
  logic            w_op_lden;
  logic            w_whilo;

  assign w_state          = div_ctrl_state_e'(r_state);
  assign w_state_nxt_bits = w_state_nxt;

  gnrl_dfflr #(.DW(2)) u_state (
    .clk    (clk),
    .rst    (rst),
    .i_lden (1'b1),
    .i_dnxt (w_state_nxt_bits),
    .o_qout (r_state)
  );

  gnrl_dfflr #(.DW(2)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_lden (1'b1),
    .i_dnxt (w_cnt_nxt),
    .o_qout (r_cnt)
  );

  gnrl_dfflr #(.DW(1)) u_start (
    .clk    (clk),
    .rst    (rst),
    .i_lden (1'b1),
    .i_dnxt (w_start_nxt),
    .o_qout (div_start_o)
  );

  gnrl_dfflr #(.DW(1)) u_annul (
    .clk    (clk),
    .rst    (rst),
    .i_lden (1'b1),
    .i_dnxt (w_annul_nxt),
    .o_qout (div_annul_o)
  );

  // Operands and signedness are captured only on the start edge, so they stay
  // frozen while the divider may re-read the sign bits at its final step.
  gnrl_dfflr #(.DW(1)) u_signed (
    .clk    (clk),
    .rst    (rst),
    .i_lden (w_op_lden),
    .i_dnxt (div_signed_i),
    .o_qout (div_signed_o)
  );

  gnrl_dfflr #(.DW(REG_WIDTH)) u_op1 (
    .clk    (clk),
    .rst    (rst),
    .i_lden (w_op_lden),
    .i_dnxt (rs_data_i),
    .o_qout (div_op1_o)
  );

  gnrl_dfflr #(.DW(REG_WIDTH)) u_op2 (
    .clk    (clk),
    .rst    (rst),
    .i_lden (w_op_lden),
    .i_dnxt (rt_data_i),
    .o_qout (div_op2_o)
  );

  // Next-state and strobe decode; flush outranks ready while busy.
  always_comb begin
    w_state_nxt = w_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = div_start_o;
    w_annul_nxt = 1'b0;
    w_op_lden   = 1'b0;
    w_whilo     = 1'b0;
    case (w_state)
      DIV_CTRL_IDLE: begin
        if (div_req_i && !flush_i) begin
          w_op_lden   = 1'b1;
          w_start_nxt = DIV_START;
          w_state_nxt = DIV_CTRL_BUSY;
        end
      end
      DIV_CTRL_BUSY: begin
        if (flush_i) begin
          w_annul_nxt = 1'b1;
          w_start_nxt = DIV_STOP;
          w_cnt_nxt   = GUARD_LOAD;
          w_state_nxt = DIV_CTRL_GUARD;
        end else if (div_ready_i) begin
          w_whilo     = !rst;
          w_start_nxt = DIV_STOP;
          w_state_nxt = DIV_CTRL_RELEASE;
        end
      end
      DIV_CTRL_RELEASE: begin
        if (!div_ready_i) begin
          w_state_nxt = DIV_CTRL_IDLE;
        end
      end
      DIV_CTRL_GUARD: begin
        if (r_cnt == 2'd0) begin
          if (!div_ready_i) begin
            w_state_nxt = DIV_CTRL_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = DIV_CTRL_IDLE;
      end
    endcase
  end

  // The pipe only advances on the completion cycle; everything else with a
  // pending request holds it.
  assign stallreq_o = div_req_i & ~w_whilo;
  assign whilo_o    = w_whilo;
  assign hi_o       = w_whilo ? div_result_i[63:32] : ZERO_WORD;
  assign lo_o       = w_whilo ? div_result_i[31:0]  : ZERO_WORD;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider stub, per-cycle reference model,
// directed scenarios and randomized request streams.
module tb_div_ctrl;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req_i = 1'b0;
  logic        div_signed_i = 1'b0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] rt_data_i = '0;
  logic        flush_i = 1'b0;
  logic [63:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        stallreq_o, whilo_o;
  logic [31:0] hi_o, lo_o;

  int n_tests = 0;
  int n_fail  = 0;
  int whilo_cnt = 0;
  int annul_cnt = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .flush_i      (flush_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // Reference arithmetic: {remainder, quotient}, divide-by-zero gives 0.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Divider stub modelled on the OpenMIPS divider: Free/ByZero/On/End.
  typedef enum logic [1:0] {D_FREE, D_ZERO, D_ON, D_END} dst_e;
  dst_e d_st = D_FREE;
  int   d_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      d_st         <= D_FREE;
      d_cnt        <= 0;
      div_ready_i  <= 1'b0;
      div_result_i <= '0;
    end else begin
      case (d_st)
        D_FREE: begin
          div_ready_i  <= 1'b0;
          div_result_i <= '0;
          if (div_start_o && !div_annul_o) begin
            if (div_op2_o == 32'd0) d_st <= D_ZERO;
            else begin
              d_st  <= D_ON;
              d_cnt <= LAT;
            end
          end
        end
        D_ZERO: begin
          d_st         <= D_END;
          div_ready_i  <= 1'b1;
          div_result_i <= '0;
        end
        D_ON: begin
          if (div_annul_o) d_st <= D_FREE;
          else if (d_cnt <= 1) begin
            d_st         <= D_END;
            div_ready_i  <= 1'b1;
            div_result_i <= ref_div(div_signed_o, div_op1_o, div_op2_o);
          end else d_cnt <= d_cnt - 1;
        end
        D_END: begin
          if (!div_start_o) begin
            d_st         <= D_FREE;
            div_ready_i  <= 1'b0;
            div_result_i <= '0;
          end
        end
        default: d_st <= D_FREE;
      endcase
    end
  end

  // Reference model: tracks whether a division is running, draining, or
  // guarded, and checks every output on every falling edge.
  bit          m_run = 0, m_drain = 0, m_start = 0, m_annul = 0, m_sgn = 0;
  int          m_guard = -1;
  logic [31:0] m_op1 = '0, m_op2 = '0;

  initial begin
    logic e_whilo;
    forever begin
      @(negedge clk);
      e_whilo = m_run && div_ready_i && !flush_i && !rst;
      chk1("start", div_start_o, m_start);
      chk1("annul", div_annul_o, m_annul);
      chk1("signed", div_signed_o, m_sgn);
      chk32("op1", div_op1_o, m_op1);
      chk32("op2", div_op2_o, m_op2);
      chk1("whilo", whilo_o, e_whilo);
      chk1("stallreq", stallreq_o, div_req_i && !e_whilo);
      chk32("hi", hi_o, e_whilo ? div_result_i[63:32] : 32'd0);
      chk32("lo", lo_o, e_whilo ? div_result_i[31:0] : 32'd0);
      if (whilo_o) whilo_cnt++;
      if (div_annul_o) annul_cnt++;
      if (rst) begin
        m_run = 0; m_drain = 0; m_start = 0; m_annul = 0; m_sgn = 0;
        m_guard = -1; m_op1 = '0; m_op2 = '0;
      end else begin
        m_annul = 0;
        if (m_run) begin
          if (flush_i) begin
            m_run = 0; m_start = 0; m_annul = 1; m_guard = 3;
          end else if (div_ready_i) begin
            m_run = 0; m_start = 0; m_drain = 1;
          end
        end else if (m_drain) begin
          if (!div_ready_i) m_drain = 0;
        end else if (m_guard >= 0) begin
          if (m_guard > 0) m_guard--;
          else if (!div_ready_i) m_guard = -1;
        end else if (div_req_i && !flush_i) begin
          m_run = 1; m_start = 1; m_sgn = div_signed_i;
          m_op1 = rs_data_i; m_op2 = rt_data_i;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int g);
    div_req_i = 1'b0;
    repeat (g) step();
  endtask

  // Hold a request like the EX stage does until the pipe releases it or a
  // flush kills it; flush_at is the cycle index (0 = first cycle) or -1.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, output int n, output logic [31:0] got_hi,
                         output logic [31:0] got_lo);
    bit fin;
    logic [63:0] exp;
    exp = ref_div(s, a, b);
    div_req_i = 1'b1; div_signed_i = s; rs_data_i = a; rt_data_i = b;
    n = 0; fin = 0; got_hi = '0; got_lo = '0;
    while (!fin) begin
      flush_i = (n == flush_at);
      @(negedge clk);
      if (flush_i) fin = 1;
      else if (!stallreq_o) begin
        fin = 1;
        got_hi = hi_o; got_lo = lo_o;
        chk1("txn_whilo", whilo_o, 1'b1);
        chk32("txn_hi", hi_o, exp[63:32]);
        chk32("txn_lo", lo_o, exp[31:0]);
      end else if (n >= 300) begin
        fin = 1;
        n_tests++; n_fail++;
        $display("FAIL txn_timeout: no completion after %0d cycles, expected under 300", n);
      end
      n++;
      step();
    end
    n = n - 1;
    flush_i = 1'b0;
    div_req_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, a0, w0;
    logic [31:0] h, l;
    repeat (3) step();
    @(negedge clk);
    chk1("rst_start", div_start_o, 1'b0);
    chk1("rst_annul", div_annul_o, 1'b0);
    chk32("rst_op1", div_op1_o, 32'd0);
    chk1("rst_whilo", whilo_o, 1'b0);
    step();
    rst = 1'b0;
    idle(2);

    // DIVU 100/7
    w0 = whilo_cnt;
    run_div(1'b0, 32'd100, 32'd7, -1, n, h, l);
    chk32("divu100_7_lo", l, 32'd14);
    chk32("divu100_7_hi", h, 32'd2);
    chk1("divu100_7_start_fall", div_start_o, 1'b0);
    idle(3);
    chk32("divu100_7_one_whilo", 32'(whilo_cnt - w0), 32'd1);

    // DIV -100/7
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, -1, n, h, l);
    chk32("div_neg_lo", l, 32'hFFFFFFF2);
    chk32("div_neg_hi", h, 32'hFFFFFFFE);
    chk32("div_neg_op1_held", div_op1_o, 32'hFFFFFF9C);
    idle(3);

    // DIVU 5/0
    run_div(1'b0, 32'd5, 32'd0, -1, n, h, l);
    chk1("divz_latency", n <= 4, 1'b1);
    chk32("divz_lo", l, 32'd0);
    chk32("divz_hi", h, 32'd0);
    idle(3);

    // Flush mid-BUSY, then an immediate new request
    a0 = annul_cnt; w0 = whilo_cnt;
    run_div(1'b0, 32'd100, 32'd7, 10, n, h, l);
    run_div(1'b0, 32'd100, 32'd7, -1, n2, h, l);
    chk32("flush_annul_pulses", 32'(annul_cnt - a0), 32'd1);
    chk32("flush_whilo_count", 32'(whilo_cnt - w0), 32'd1);
    chk1("flush_guard_wait", n2 >= 4 + LAT, 1'b1);
    chk32("flush_next_lo", l, 32'd14);
    chk32("flush_next_hi", h, 32'd2);
    idle(3);

    // DIV 5/0 flushed early, immediate DIVU 9/2
    w0 = whilo_cnt;
    run_div(1'b1, 32'd5, 32'd0, 2, n, h, l);
    run_div(1'b0, 32'd9, 32'd2, -1, n, h, l);
    chk32("stale_lo", l, 32'd4);
    chk32("stale_hi", h, 32'd1);
    chk32("stale_whilo_count", 32'(whilo_cnt - w0), 32'd1);
    idle(3);

    // Reset mid-BUSY
    w0 = whilo_cnt;
    div_req_i = 1'b1; div_signed_i = 1'b1; rs_data_i = 32'd100; rt_data_i = 32'd7;
    repeat (6) step();
    rst = 1'b1; div_req_i = 1'b0;
    step();
    rst = 1'b0;
    chk1("rstb_start", div_start_o, 1'b0);
    chk1("rstb_signed", div_signed_o, 1'b0);
    chk32("rstb_op1", div_op1_o, 32'd0);
    chk32("rstb_op2", div_op2_o, 32'd0);
    chk32("rstb_no_whilo", 32'(whilo_cnt - w0), 32'd0);
    idle(1);

    // Back-to-back DIVU
    w0 = whilo_cnt;
    run_div(1'b0, 32'd1000, 32'd3, -1, n, h, l);
    run_div(1'b0, 32'd77, 32'd5, -1, n, h, l);
    chk32("b2b_lo", l, 32'd15);
    chk32("b2b_hi", h, 32'd2);
    chk32("b2b_whilo_count", 32'(whilo_cnt - w0), 32'd2);
    idle(2);

    // Randomized stream
    for (int i = 0; i < 60; i++) begin
      logic        s;
      logic [31:0] a, b;
      int          fa;
      s  = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_div(s, a, b, fa, n, h, l);
      idle($urandom_range(0, 2));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
